// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB, turns decoder levels into one-cycle strobes.
// Latency 3-5 cycles with single-cycle acks; req held until ack, timeout to sticky ERR. Perf counters: MIPS_CTRL_PERF_EN.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
`ifdef MIPS_CTRL_PERF_EN
    , parameter int CNT_W     = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       im_req,
    input  logic       im_ack,
    output logic       ir_we,
    input  logic       dec_regwr,
    input  logic       dec_memwr,
    input  logic       dec_memtoreg,
    input  logic       dec_branch,
    input  logic       dec_jump,
    input  logic       dec_jumpreg,
    input  logic       dec_jrwr,
    input  logic       br_taken,
    output logic       dm_req,
    output logic       dm_we,
    input  logic       dm_ack,
    output logic       rf_we,
    output logic       rf_link,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       retire,
    output logic       busy,
    output logic       err
`ifdef MIPS_CTRL_PERF_EN
    , output logic [CNT_W-1:0] cycle_cnt
    , output logic [CNT_W-1:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [TO_W-1:0] wait_cnt, wait_nxt;
    logic            to_hit;
    logic            ack_seen;
    logic            waiting;
    logic            retire_now;

    assign to_hit   = (MEM_TIMEOUT != 0) && (wait_cnt >= TO_LAST);
    assign waiting  = (state == FETCH) || (state == MEM);
    assign ack_seen = ((state == FETCH) && im_ack) || ((state == MEM) && dm_ack);
    assign busy     = (state != IDLE) && (state != ERR);
    assign err      = (state == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Counter restarts on every state entry so FETCH and MEM waits are timed independently.
    always_comb begin
        wait_nxt = wait_cnt;
        if ((state_nxt != state) || ack_seen)
            wait_nxt = '0;
        else if (waiting && (wait_cnt != {TO_W{1'b1}}))
            wait_nxt = wait_cnt + 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        im_req     = 1'b0;
        ir_we      = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        rf_we      = 1'b0;
        rf_link    = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        retire     = 1'b0;
        retire_now = 1'b0;
        case (state)
            IDLE:   if (run) state_nxt = FETCH;
            FETCH: begin
                im_req = 1'b1;
                if (im_ack) begin
                    ir_we     = 1'b1;
                    state_nxt = DECODE;
                end else if (to_hit) begin
                    state_nxt = ERR;
                end
            end
            DECODE: state_nxt = EXEC;
            EXEC: begin
                if (dec_memwr || dec_memtoreg)
                    state_nxt = MEM;
                else if (dec_branch || (dec_jump && !dec_jrwr) || (dec_jumpreg && !dec_regwr))
                    retire_now = 1'b1;
                else
                    state_nxt = WB;
            end
            MEM: begin
                dm_req = 1'b1;
                dm_we  = dec_memwr;
                if (dm_ack) begin
                    if (dec_memwr) retire_now = 1'b1;
                    else           state_nxt  = WB;
                end else if (to_hit) begin
                    state_nxt = ERR;
                end
            end
            // Only writers reach WB, including jal whose RegWr is low.
            WB: begin
                rf_we      = 1'b1;
                rf_link    = dec_jrwr;
                retire_now = 1'b1;
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
        if (retire_now) begin
            retire    = 1'b1;
            pc_we     = 1'b1;
            pc_src    = dec_jumpreg ? 2'd3 : dec_jump ? 2'd2 : (dec_branch && br_taken) ? 2'd1 : 2'd0;
            state_nxt = run ? FETCH : IDLE;
        end
        // Reset cycle must not leak a request, write or retire from the aborted instruction.
        if (rst) begin
            im_req  = 1'b0;
            ir_we   = 1'b0;
            dm_req  = 1'b0;
            dm_we   = 1'b0;
            rf_we   = 1'b0;
            rf_link = 1'b0;
            pc_we   = 1'b0;
            pc_src  = 2'd0;
            retire  = 1'b0;
        end
    end

`ifdef MIPS_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy)   cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction stream against a per-instruction cycle/strobe model, plus timeout and reset cases.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic regwr, memwr, memtoreg, branch, jump, jumpreg, jrwr;
    } dec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, run, im_ack, dm_ack, br_taken;
    logic im_req, ir_we, dm_req, dm_we, rf_we, rf_link, pc_we, retire, busy, err;
    logic [1:0] pc_src;
    dec_t dec;
`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .run(run),
        .im_req(im_req), .im_ack(im_ack), .ir_we(ir_we),
        .dec_regwr(dec.regwr), .dec_memwr(dec.memwr), .dec_memtoreg(dec.memtoreg),
        .dec_branch(dec.branch), .dec_jump(dec.jump), .dec_jumpreg(dec.jumpreg),
        .dec_jrwr(dec.jrwr), .br_taken(br_taken),
        .dm_req(dm_req), .dm_we(dm_we), .dm_ack(dm_ack),
        .rf_we(rf_we), .rf_link(rf_link), .pc_we(pc_we), .pc_src(pc_src),
        .retire(retire), .busy(busy), .err(err)
`ifdef MIPS_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;
    int busy_sum = 0;
    int n_retired = 0;
    dec_t itab [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One instruction from its FETCH cycle to its retire cycle; returns one cycle after retire.
    task automatic run_instr(input dec_t d, input logic bt, input int imd, input int dmd, input bit drop);
        int  cyc = 0, n_im = 0, n_ir = 0, n_dm = 0, n_dmwe = 0, n_rf = 0, n_pcwe = 0, n_busy = 0;
        int  link = 0, psrc = 0, exp_cyc;
        bit  done = 0, mem, exec_ret, wb;
        dec = d;
        br_taken = bt;
        while (!done && cyc < 40) begin
            im_ack = im_req ? (n_im == imd) : 1'($urandom % 2);
            dm_ack = dm_req ? (n_dm == dmd) : 1'($urandom % 2);
            if (drop && cyc == 1) run = 1'b0;
            #1;
            cyc++;
            n_im += int'(im_req);  n_ir += int'(ir_we);  n_dm += int'(dm_req);
            n_dmwe += int'(dm_we); n_rf += int'(rf_we);  n_pcwe += int'(pc_we);
            n_busy += int'(busy);
            if (rf_we) link = int'(rf_link);
            if (retire) begin
                psrc = int'(pc_src);
                done = 1;
            end
            @(posedge clk); #1;
        end
        mem      = d.memwr || d.memtoreg;
        exec_ret = !mem && (d.branch || (d.jump && !d.jrwr) || (d.jumpreg && !d.regwr));
        wb       = d.memtoreg || (!mem && !exec_ret);
        exp_cyc  = (imd + 1) + 2 + (mem ? dmd + 1 : 0) + (wb ? 1 : 0);
        check("retired", done, 1);
        check("cycles", cyc, exp_cyc);
        check("busy_cycles", n_busy, exp_cyc);
        check("im_req_cycles", n_im, imd + 1);
        check("ir_we_pulses", n_ir, 1);
        check("dm_req_cycles", n_dm, mem ? dmd + 1 : 0);
        check("dm_we_cycles", n_dmwe, d.memwr ? dmd + 1 : 0);
        check("rf_we_pulses", n_rf, wb ? 1 : 0);
        check("rf_link", link, wb ? int'(d.jrwr) : 0);
        check("pc_we_pulses", n_pcwe, 1);
        check("pc_src", psrc, d.jumpreg ? 3 : d.jump ? 2 : (d.branch && bt) ? 1 : 0);
        busy_sum += exp_cyc;
        n_retired++;
        if (drop) begin
            im_ack = 1'b0;
            dm_ack = 1'b0;
            #1;
            check("idle_after_drop_busy", busy, 0);
            check("idle_after_drop_im_req", im_req, 0);
            run = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        im_ack = 1'b0;
        dm_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int  n, cls, imd, dmd;
        bit  found;
        //               regwr memwr m2r br  j   jr  jrwr
        itab[0] = dec_t'(7'b1_0_0_0_0_0_0); // addu
        itab[1] = dec_t'(7'b1_0_1_0_0_0_0); // lw
        itab[2] = dec_t'(7'b0_1_0_0_0_0_0); // sw
        itab[3] = dec_t'(7'b0_0_0_1_0_0_0); // beq
        itab[4] = dec_t'(7'b0_0_0_0_1_0_0); // j
        itab[5] = dec_t'(7'b0_0_0_0_0_1_0); // jr
        itab[6] = dec_t'(7'b0_0_0_0_1_0_1); // jal
        itab[7] = dec_t'(7'b1_0_0_0_0_1_1); // jalr
        dec = '0;
        br_taken = 1'b0;

        rst = 1'b1; run = 1'b0; im_ack = 1'b1; dm_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes", {im_req, ir_we, dm_req, dm_we, rf_we, rf_link, pc_we, pc_src, retire}, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        do_reset();

        // Instruction fetch never acknowledged.
        run = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && !err; i++) begin
            n += int'(im_req);
            @(posedge clk); #1;
        end
        check("timeout_req_cycles", n, 4);
        check("timeout_err", err, 1);
        check("timeout_busy", busy, 0);
        check("timeout_im_req", im_req, 0);
        im_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", err, 1);
        check("err_no_fetch", ir_we, 0);
        do_reset();
        check("err_cleared", err, 0);

        // Reset while a store waits in MEM.
        dec = itab[2];
        run = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            im_ack = im_req;
            dm_ack = 1'b0;
            #1;
            if (dm_req) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rst_mem_reached", found, 1);
        rst = 1'b1;
        #1;
        check("rst_mem_dm_req", dm_req, 0);
        check("rst_mem_retire", retire, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run = 1'b0;
        #1;
        check("rst_mem_idle", busy, 0);
        check("rst_mem_no_retire", {retire, pc_we, dm_req, rf_we}, 0);
        do_reset();

        run = 1'b1;
        busy_sum = 0;
        n_retired = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 60; i++) begin
            if (i < 10) begin
                cls = 0; imd = 0; dmd = 0;
            end else begin
                cls = int'($urandom_range(0, 7));
                imd = int'($urandom_range(0, 3));
                dmd = int'($urandom_range(0, 3));
            end
            run_instr(itab[cls], 1'($urandom % 2), imd, dmd, (i >= 10) && ($urandom % 4 == 0));
`ifdef MIPS_CTRL_PERF_EN
            if (i == 9) begin
                check("perf_instr_10addu", instr_cnt, 10);
                check("perf_cycle_10addu", cycle_cnt, 40);
            end
`endif
        end
`ifdef MIPS_CTRL_PERF_EN
        check("perf_instr_cnt", instr_cnt, n_retired);
        check("perf_cycle_cnt", cycle_cnt, busy_sum);
`endif
        check("final_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
